// File: rtl/clint_mh.sv
// clint_mh -- multi-hart Core Local Interruptor on a Wishbone slave port.
//
// A shared 64-bit mtime advances once every TICK_DIV clocks. Each hart has
// its own 64-bit mtimecmp and a 1-bit msip. Both interrupt outputs are
// registered and therefore lag the register state by one cycle.
//
// Handshake: a request is valid while wb_cyc_i & wb_stb_i. A valid request
// that is not already being acknowledged is accepted on a clock edge. On that
// same edge a write commits, read data is captured, and wb_ack_o rises for
// exactly one cycle. wb_dat_o is zero whenever wb_ack_o is low.
//
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   wb_cyc_i, wb_stb_i       Wishbone cycle / strobe
//   wb_we_i                  1 = write
//   wb_adr_i[31:0]           byte address; only [15:2] is decoded
//   wb_dat_i[31:0]           write data
//   wb_sel_i[3:0]            byte-lane enables
//   wb_dat_o[31:0]           registered read data
//   wb_ack_o                 single-cycle acknowledge
//   timer_irq_o[NUM_HARTS]   MTIP per hart (mtime >= mtimecmp[h])
//   soft_irq_o[NUM_HARTS]    MSIP per hart
module clint_mh #(
  parameter int NUM_HARTS = 2,
  parameter int TICK_DIV  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  input  logic [31:0]          wb_adr_i,
  input  logic [31:0]          wb_dat_i,
  input  logic [3:0]           wb_sel_i,
  output logic [31:0]          wb_dat_o,
  output logic                 wb_ack_o,
  output logic [NUM_HARTS-1:0] timer_irq_o,
  output logic [NUM_HARTS-1:0] soft_irq_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(TICK_DIV - 1);

  logic [63:0]          mtime_q;
  logic [PW-1:0]        ps_q;
  logic [63:0]          mtimecmp_q [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip_q;
  logic                 ack_q;
  logic [31:0]          dat_q;
  logic [NUM_HARTS-1:0] timer_irq_q;
  logic [NUM_HARTS-1:0] soft_irq_q;

  logic        access;
  logic        wr;
  logic        tick;
  logic [15:0] off;
  logic        sel_msip, sel_cmp, sel_mtime, hi;
  logic [3:0]  hart_msip, hart_cmp;
  logic [31:0] rdata;
  logic        unused_adr;

  // Accept only when not already acknowledging, so a held request is
  // serviced every other cycle.
  assign access = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr     = access & wb_we_i;
  assign tick   = (ps_q == PS_MAX);
  assign off    = wb_adr_i[15:0];

  // Region decode. The per-hart index is matched inside the loops below,
  // so an index at or beyond NUM_HARTS matches nothing and behaves as
  // unmapped.
  assign sel_msip  = (off[15:6] == 10'h000);
  assign sel_cmp   = (off[15:7] == 9'h080);
  assign sel_mtime = (off[15:3] == 13'h17FF);
  assign hi        = off[2];
  assign hart_msip = off[5:2];
  assign hart_cmp  = off[6:3];

  assign unused_adr = ^{wb_adr_i[31:16], wb_adr_i[1:0]};

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    for (int k = 0; k < 4; k++) begin
      res[8*k +: 8] = sel[k] ? new_v[8*k +: 8] : old_v[8*k +: 8];
    end
    return res;
  endfunction

  always_comb begin
    rdata = 32'h0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (sel_msip && hart_msip == 4'(h)) rdata = {31'h0, msip_q[h]};
      if (sel_cmp && hart_cmp == 4'(h)) begin
        rdata = hi ? mtimecmp_q[h][63:32] : mtimecmp_q[h][31:0];
      end
    end
    if (sel_mtime) rdata = hi ? mtime_q[63:32] : mtime_q[31:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mtime_q     <= 64'h0;
      ps_q        <= '0;
      msip_q      <= '0;
      ack_q       <= 1'b0;
      dat_q       <= 32'h0;
      timer_irq_q <= '0;
      soft_irq_q  <= '0;
      for (int h = 0; h < NUM_HARTS; h++) mtimecmp_q[h] <= '1;
    end else begin
      ack_q <= access;
      dat_q <= (access && !wb_we_i) ? rdata : 32'h0;

      // A software write to mtime wins over the tick and restarts the
      // prescaler; only the addressed half changes, with no carry.
      if (wr && sel_mtime) begin
        ps_q <= '0;
        if (hi) mtime_q[63:32] <= merge_lanes(mtime_q[63:32], wb_dat_i, wb_sel_i);
        else    mtime_q[31:0]  <= merge_lanes(mtime_q[31:0], wb_dat_i, wb_sel_i);
      end else if (tick) begin
        ps_q    <= '0;
        mtime_q <= mtime_q + 64'h1;
      end else begin
        ps_q <= ps_q + 1'b1;
      end

      for (int h = 0; h < NUM_HARTS; h++) begin
        if (wr && sel_cmp && hart_cmp == 4'(h)) begin
          if (hi) mtimecmp_q[h][63:32] <= merge_lanes(mtimecmp_q[h][63:32], wb_dat_i, wb_sel_i);
          else    mtimecmp_q[h][31:0]  <= merge_lanes(mtimecmp_q[h][31:0], wb_dat_i, wb_sel_i);
        end
        if (wr && sel_msip && hart_msip == 4'(h) && wb_sel_i[0]) msip_q[h] <= wb_dat_i[0];
        timer_irq_q[h] <= (mtime_q >= mtimecmp_q[h]);
      end
      soft_irq_q <= msip_q;
    end
  end

  assign wb_ack_o    = ack_q;
  assign wb_dat_o    = dat_q;
  assign timer_irq_o = timer_irq_q;
  assign soft_irq_o  = soft_irq_q;

endmodule

// File: tb/tb_clint_mh.sv
// tb_clint_mh -- self-checking bench for clint_mh (NUM_HARTS=2, TICK_DIV=4).
// The reference model keeps mtime as "value written at edge E" and derives
// later values arithmetically from the elapsed edge count.
module tb_clint_mh;
  localparam int NH = 2;
  localparam int TD = 4;
  localparam logic [31:0] BASE = 32'h0200_0000;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          wb_cyc_i = 1'b0;
  logic          wb_stb_i = 1'b0;
  logic          wb_we_i = 1'b0;
  logic [31:0]   wb_adr_i = 32'h0;
  logic [31:0]   wb_dat_i = 32'h0;
  logic [3:0]    wb_sel_i = 4'h0;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o;
  logic [NH-1:0] timer_irq_o;
  logic [NH-1:0] soft_irq_o;

  clint_mh #(.NUM_HARTS(NH), .TICK_DIV(TD)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .timer_irq_o(timer_irq_o), .soft_irq_o(soft_irq_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  int edge_cnt = 0;
  always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  logic [63:0]   base_val;
  int            base_edge;
  logic [63:0]   cmp_m [NH];
  logic [NH-1:0] msip_m;
  logic [31:0]   exp_q [$];

  function automatic logic [31:0] merge32(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = s[k] ? n[8*k +: 8] : o[8*k +: 8];
    return r;
  endfunction

  // mtime held in the register after edge n.
  function automatic logic [63:0] mt_at(input int n);
    return base_val + 64'((n - base_edge) / TD);
  endfunction

  task automatic model_reset(input int n);
    base_val  = 64'h0;
    base_edge = n;
    msip_m    = '0;
    for (int h = 0; h < NH; h++) cmp_m[h] = '1;
  endtask

  // Value returned by a read whose sampling edge is n.
  function automatic logic [31:0] model_read(input logic [15:0] off, input int n);
    int o;
    o = int'(off);
    if (o < 4 * NH) return {31'h0, msip_m[o / 4]};
    if (o >= 32'h4000 && o < 32'h4000 + 8 * NH)
      return ((o - 32'h4000) % 8 >= 4) ? cmp_m[(o - 32'h4000) / 8][63:32]
                                       : cmp_m[(o - 32'h4000) / 8][31:0];
    if (o == 32'hBFF8) return mt_at(n - 1) & 64'hFFFF_FFFF;
    if (o == 32'hBFFC) return mt_at(n - 1) >> 32;
    return 32'h0;
  endfunction

  task automatic model_write(input logic [15:0] off, input logic [31:0] d,
                             input logic [3:0] s, input int n);
    int o;
    logic [63:0] cur;
    o = int'(off);
    if (o < 4 * NH) begin
      if (s[0]) msip_m[o / 4] = d[0];
    end else if (o >= 32'h4000 && o < 32'h4000 + 8 * NH) begin
      if ((o - 32'h4000) % 8 >= 4)
        cmp_m[(o - 32'h4000) / 8][63:32] = merge32(cmp_m[(o - 32'h4000) / 8][63:32], d, s);
      else
        cmp_m[(o - 32'h4000) / 8][31:0] = merge32(cmp_m[(o - 32'h4000) / 8][31:0], d, s);
    end else if (o == 32'hBFF8 || o == 32'hBFFC) begin
      cur = mt_at(n - 1);
      if (o == 32'hBFFC) cur[63:32] = merge32(cur[63:32], d, s);
      else               cur[31:0]  = merge32(cur[31:0], d, s);
      base_val  = cur;
      base_edge = n;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  // ---------------- drivers ----------------
  task automatic xfer(input string tag, input logic we, input logic [15:0] off,
                      input logic [31:0] d, input logic [3:0] s);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = BASE | {16'h0, off}; wb_dat_i = d; wb_sel_i = s;
    if (!we) exp_q.push_back(model_read(off, edge_cnt + 1));
    @(posedge clk_i); #1;
    check({tag, "_ack"}, 64'(wb_ack_o), 64'h1);
    if (we) model_write(off, d, s, edge_cnt);
    else check(tag, 64'(wb_dat_o), 64'(exp_q.pop_front()));
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge clk_i); #1;
    check("ack_drop", 64'(wb_ack_o), 64'h0);
  endtask

  task automatic wr(input logic [15:0] off, input logic [31:0] d, input logic [3:0] s);
    xfer("wr", 1'b1, off, d, s);
  endtask

  task automatic rd(input string tag, input logic [15:0] off);
    xfer(tag, 1'b0, off, 32'h0, 4'hF);
  endtask

  // Per-cycle IRQ and idle-bus checks against the model.
  task automatic idle_check(input int cycles);
    logic [NH-1:0] exp_t;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk_i); #1;
      for (int h = 0; h < NH; h++) exp_t[h] = (mt_at(edge_cnt - 1) >= cmp_m[h]);
      check("timer_irq", 64'(timer_irq_o), 64'(exp_t));
      check("soft_irq", 64'(soft_irq_o), 64'(msip_m));
      check("bus_idle", {31'h0, wb_ack_o, wb_dat_o}, 64'h0);
    end
  endtask

  task automatic read_all();
    rd("msip0", 16'h0000); rd("msip1", 16'h0004);
    rd("cmp0_lo", 16'h4000); rd("cmp0_hi", 16'h4004);
    rd("cmp1_lo", 16'h4008); rd("cmp1_hi", 16'h400C);
    rd("mtime_lo", 16'hBFF8); rd("mtime_hi", 16'hBFFC);
  endtask

  logic [15:0] offs [12] = '{16'h0000, 16'h0004, 16'h0008, 16'h4000, 16'h4004, 16'h4008,
                              16'h400C, 16'h4010, 16'hBFF8, 16'hBFFC, 16'h1234, 16'hBFF0};

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] t;
    int h;
    // Reset
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    model_reset(edge_cnt);
    rst_ni = 1'b1;
    check("rst_ack", 64'(wb_ack_o), 64'h0);
    check("rst_dat", 64'(wb_dat_o), 64'h0);
    check("rst_tirq", 64'(timer_irq_o), 64'h0);
    check("rst_sirq", 64'(soft_irq_o), 64'h0);
    read_all();
    idle_check(2);

    // mtime LO=0 then 40 cycles with TICK_DIV=4
    wr(16'hBFF8, 32'h0, 4'hF);
    idle_check(40);
    rd("mtime_after40", 16'hBFF8);

    // Timer compare on hart 1 twenty ticks ahead
    t = mt_at(edge_cnt) + 64'd20;
    wr(16'h400C, t[63:32], 4'hF);
    wr(16'h4008, t[31:0], 4'hF);
    idle_check(100);
    check("tirq1_set", 64'(timer_irq_o), 64'h2);
    wr(16'h400C, 32'hFFFF_FFFF, 4'hF);
    idle_check(3);

    // msip byte-lane behaviour
    wr(16'h0000, 32'hFFFF_FFFF, 4'b0001);
    rd("msip0_set", 16'h0000);
    idle_check(1);
    check("sirq_01", 64'(soft_irq_o), 64'h1);
    wr(16'h0000, 32'h0, 4'b0000);
    rd("msip0_keep", 16'h0000);
    idle_check(2);

    // Unmapped offsets: read zero, writes ignored
    rd("unmap_4010", 16'h4010);
    rd("unmap_1234", 16'h1234);
    wr(16'h4010, 32'hDEAD_BEEF, 4'hF);
    wr(16'h1234, 32'hDEAD_BEEF, 4'hF);
    read_all();

    // Held request: ack on every other cycle only
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_adr_i = BASE; wb_sel_i = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #1;
      check("hold_ack", 64'(wb_ack_o), (i % 2 == 0) ? 64'h1 : 64'h0);
      check("hold_dat", 64'(wb_dat_o), (i % 2 == 0) ? 64'(msip_m[0]) : 64'h0);
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    idle_check(2);

    // mtime wrap through a compare value: IRQ asserts, then drops at wrap
    wr(16'hBFFC, 32'hFFFF_FFFF, 4'hF);
    wr(16'hBFF8, 32'hFFFF_FFF0, 4'hF);
    wr(16'h4000, 32'hFFFF_FFF4, 4'hF);
    idle_check(90);

    // Carry from LO into HI
    wr(16'hBFFC, 32'h0, 4'hF);
    wr(16'hBFF8, 32'hFFFF_FFFE, 4'hF);
    idle_check(12);
    rd("carry_hi", 16'hBFFC);
    rd("carry_lo", 16'hBFF8);

    // Randomized traffic
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 4))
        0: rd("rand_rd", offs[$urandom_range(0, 11)]);
        1: begin
          h = $urandom_range(0, NH - 1);
          t = mt_at(edge_cnt) + 64'($urandom_range(0, 40));
          wr(16'(32'h4004 + 8 * h), t[63:32], 4'hF);
          wr(16'(32'h4000 + 8 * h), t[31:0], 4'hF);
        end
        2: wr(16'(4 * $urandom_range(0, NH - 1)), $urandom, 4'($urandom_range(0, 15)));
        3: wr(offs[$urandom_range(0, 11)], $urandom, 4'($urandom_range(0, 15)));
        default: idle_check($urandom_range(1, 30));
      endcase
      idle_check(1);
    end
    read_all();

    // Reset in the middle of a request: no ack, state cleared
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = BASE | 32'h4; wb_dat_i = 32'h1; wb_sel_i = 4'hF;
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    check("midrst_ack", 64'(wb_ack_o), 64'h0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge clk_i); #1;
    model_reset(edge_cnt);
    rst_ni = 1'b1;
    check("midrst_tirq", 64'(timer_irq_o), 64'h0);
    check("midrst_sirq", 64'(soft_irq_o), 64'h0);
    read_all();
    idle_check(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
